// File: rtl/pwm_ramp_ctrl.sv
// Sequencing controller for a PWM generator: accepts period/duty requests, reloads the
// generator on a period change, then slews the duty toward its target in dwell-paced steps.
module pwm_ramp_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int STEP_WIDTH = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfgValid,
  output logic                  cfgReady,
  input  logic [DATA_WIDTH-1:0] cfgPeriod,
  input  logic [DATA_WIDTH-1:0] cfgTargetDuty,
  input  logic [STEP_WIDTH-1:0] cfgStep,
  input  logic [DATA_WIDTH-1:0] cfgDwell,
  input  logic                  abort,
  output logic                  pwmRstN,
  output logic [DATA_WIDTH-1:0] pwmPeriod,
  output logic [DATA_WIDTH-1:0] pwmDutyCycle,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  cfgErr,
  output logic [1:0]            state_dbg
);

  // Handshake: a request transfers on a rising clk edge where cfgValid && cfgReady;
  // cfgReady depends only on registered state, so the requester may hold cfgValid freely.

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RELOAD = 2'd1,
    S_RAMP   = 2'd2
  } state_t;

  state_t                state, next_state;
  logic                  ready_en;
  logic [RCW-1:0]        rst_cnt;
  logic [DATA_WIDTH-1:0] dwell_cnt, dwell_q, tgt_q;
  logic [STEP_WIDTH-1:0] step_q;

  logic                  accept, cfg_bad, need_reload, dwell_hit;
  logic [DATA_WIDTH-1:0] cfg_dwell_eff, cfg_tgt, step_dw, dn_val, next_duty;
  logic [DATA_WIDTH:0]   step_ext, duty_ext, tgt_ext, up_sum, dn_floor;

  assign accept        = cfgValid & cfgReady;
  assign cfg_bad       = (cfgPeriod == '0);
  assign need_reload   = (cfgPeriod != pwmPeriod) | ~pwmRstN;
  assign cfg_dwell_eff = (cfgDwell == '0) ? DATA_WIDTH'(1) : cfgDwell;
  assign cfg_tgt       = (cfgTargetDuty > cfgPeriod) ? cfgPeriod : cfgTargetDuty;
  assign dwell_hit     = (dwell_cnt == DATA_WIDTH'(1));

  // Step arithmetic is one bit wider so duty+step can never wrap past the clamp.
  assign step_dw  = DATA_WIDTH'(step_q);
  assign step_ext = {1'b0, step_dw};
  assign duty_ext = {1'b0, pwmDutyCycle};
  assign tgt_ext  = {1'b0, tgt_q};
  assign up_sum   = duty_ext + step_ext;
  assign dn_floor = tgt_ext + step_ext;
  assign dn_val   = pwmDutyCycle - step_dw;

  always_comb begin
    next_duty = tgt_q;
    if (step_q != '0) begin
      if (pwmDutyCycle < tgt_q)
        next_duty = (up_sum >= tgt_ext) ? tgt_q : up_sum[DATA_WIDTH-1:0];
      else
        next_duty = (duty_ext >= dn_floor) ? dn_val : tgt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:
        if (accept && !cfg_bad) next_state = need_reload ? S_RELOAD : S_RAMP;
      S_RELOAD:
        if (abort)              next_state = S_IDLE;
        else if (rst_cnt == '0) next_state = S_RAMP;
      S_RAMP:
        if (abort)                                 next_state = S_IDLE;
        else if (pwmDutyCycle == tgt_q)            next_state = S_IDLE;
        else if (dwell_hit && next_duty == tgt_q)  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cfgReady  = ready_en && (state == S_IDLE);
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_en     <= 1'b0;
      pwmRstN      <= 1'b0;
      pwmPeriod    <= '0;
      pwmDutyCycle <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cfgErr       <= 1'b0;
      rst_cnt      <= '0;
      dwell_cnt    <= '0;
      dwell_q      <= '0;
      tgt_q        <= '0;
      step_q       <= '0;
    end else begin
      ready_en <= 1'b1;
      done     <= 1'b0;
      aborted  <= 1'b0;
      cfgErr   <= 1'b0;
      case (state)
        S_IDLE:
          if (accept) begin
            if (cfg_bad) begin
              cfgErr <= 1'b1;
            end else begin
              tgt_q   <= cfg_tgt;
              step_q  <= cfgStep;
              dwell_q <= cfg_dwell_eff;
              if (need_reload) begin
                pwmPeriod    <= cfgPeriod;
                pwmDutyCycle <= '0;
                pwmRstN      <= 1'b0;
                rst_cnt      <= RCW'(RST_CYCLES - 1);
              end else begin
                dwell_cnt <= cfg_dwell_eff;
              end
            end
          end
        S_RELOAD:
          if (abort) begin
            pwmRstN <= 1'b1;
            aborted <= 1'b1;
          end else if (rst_cnt == '0) begin
            pwmRstN   <= 1'b1;
            dwell_cnt <= dwell_q;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        S_RAMP:
          if (abort) begin
            aborted <= 1'b1;
          end else if (pwmDutyCycle == tgt_q) begin
            done <= 1'b1;
          end else if (dwell_hit) begin
            pwmDutyCycle <= next_duty;
            dwell_cnt    <= dwell_q;
            if (next_duty == tgt_q) done <= 1'b1;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: per-cycle comparison of every output against a timeline
// predicted from the request (reload length, step list, dwell spacing, abort point).
module tb_pwm_ramp_ctrl;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfgValid = 1'b0;
  logic          cfgReady;
  logic [DW-1:0] cfgPeriod = '0;
  logic [DW-1:0] cfgTargetDuty = '0;
  logic [SW-1:0] cfgStep = '0;
  logic [DW-1:0] cfgDwell = '0;
  logic          abort = 1'b0;
  logic          pwmRstN;
  logic [DW-1:0] pwmPeriod;
  logic [DW-1:0] pwmDutyCycle;
  logic          busy, done, aborted, cfgErr;
  logic [1:0]    state_dbg;

  pwm_ramp_ctrl #(.DATA_WIDTH(DW), .STEP_WIDTH(SW), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .cfgValid(cfgValid), .cfgReady(cfgReady),
    .cfgPeriod(cfgPeriod), .cfgTargetDuty(cfgTargetDuty), .cfgStep(cfgStep),
    .cfgDwell(cfgDwell), .abort(abort), .pwmRstN(pwmRstN), .pwmPeriod(pwmPeriod),
    .pwmDutyCycle(pwmDutyCycle), .busy(busy), .done(done), .aborted(aborted),
    .cfgErr(cfgErr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the generator is currently programmed with.
  longint m_period  = 0;
  longint m_duty    = 0;
  bit     m_running = 0;

  logic [DW-1:0] exp_q[$];
  longint nxt_p, nxt_t, nxt_s;
  int     nxt_d;

  function automatic longint duty_at(int tt, int t0, int dd, longint start);
    int k;
    if (tt < t0) return start;
    k = (tt - t0) / dd;
    if (k > exp_q.size()) k = exp_q.size();
    return (k == 0) ? start : longint'(exp_q[k-1]);
  endfunction

  task automatic drive_cfg(input longint p, input longint t, input longint s, input int d);
    cfgValid      = 1'b1;
    cfgPeriod     = p[DW-1:0];
    cfgTargetDuty = t[DW-1:0];
    cfgStep       = s[SW-1:0];
    cfgDwell      = DW'(d);
  endtask

  task automatic run_cfg(input longint p, input longint t, input longint s, input int d,
                         input int abort_at, input bit chain, input int exp_wait);
    bit ok; int waited; bit reload; bit taken;
    longint tgt, start, cur, e_duty; int dd, t0, t_end, t_last;
    bit e_rstn, e_done, e_busy, e_ab;
    drive_cfg(p, t, s, d);
    ok = 0; waited = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cfgReady === 1'b1) begin ok = 1; break; end
      waited++;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout p=%0d got cfgReady=%b required 1", p, cfgReady);
      cfgValid = 1'b0;
      return;
    end
    if (exp_wait >= 0) begin
      n_cmp++;
      if (waited != exp_wait) begin
        n_bad++;
        $display("FAIL accept_wait got=%0d required=%0d", waited, exp_wait);
      end
    end
    @(posedge clk); #1;
    if (chain) drive_cfg(nxt_p, nxt_t, nxt_s, nxt_d);
    else cfgValid = 1'b0;

    if (p == 0) begin
      for (int tt = 0; tt <= 2; tt++) begin
        if (tt > 0) begin @(posedge clk); #1; end
        n_cmp++;
        if (cfgErr !== (tt == 0)) begin n_bad++;
          $display("FAIL cfg_err t=%0d got=%b required=%b", tt, cfgErr, tt == 0); end
        n_cmp++;
        if (pwmPeriod !== m_period[DW-1:0] || pwmDutyCycle !== m_duty[DW-1:0] ||
            pwmRstN !== m_running || busy !== 1'b0) begin n_bad++;
          $display("FAIL err_hold t=%0d got per=%0d duty=%0d rstn=%b busy=%b required %0d %0d %b 0",
                   tt, pwmPeriod, pwmDutyCycle, pwmRstN, busy, m_period, m_duty, m_running); end
      end
      return;
    end

    reload = (p != m_period) || !m_running;
    tgt    = (t > p) ? p : t;
    dd     = (d == 0) ? 1 : d;
    t0     = reload ? RC : 0;
    start  = reload ? 0 : m_duty;
    exp_q.delete();
    cur = start;
    while (cur != tgt) begin
      if (s == 0)          cur = tgt;
      else if (cur < tgt)  cur = (cur + s > tgt) ? tgt : cur + s;
      else                 cur = (cur - s < tgt) ? tgt : cur - s;
      exp_q.push_back(cur[DW-1:0]);
    end
    t_end  = (exp_q.size() > 0) ? t0 + exp_q.size() * dd : t0 + 1;
    taken  = (abort_at > 0) && (abort_at <= t_end);
    t_last = chain ? t_end : ((taken ? abort_at : t_end) + 2);

    for (int tt = 0; tt <= t_last; tt++) begin
      if (tt > 0) begin @(posedge clk); #1; end
      e_duty = duty_at(tt, t0, dd, start);
      e_rstn = reload ? (tt >= RC) : 1'b1;
      e_done = (tt == t_end);
      e_busy = (tt < t_end);
      e_ab   = 1'b0;
      if (taken && tt >= abort_at) begin
        e_duty = duty_at(abort_at - 1, t0, dd, start);
        e_rstn = 1'b1; e_done = 1'b0; e_busy = 1'b0; e_ab = (tt == abort_at);
      end
      n_cmp++;
      if (pwmDutyCycle !== e_duty[DW-1:0]) begin n_bad++;
        $display("FAIL duty t=%0d got=%0h required=%0h", tt, pwmDutyCycle, e_duty[DW-1:0]); end
      n_cmp++;
      if (pwmPeriod !== p[DW-1:0]) begin n_bad++;
        $display("FAIL period t=%0d got=%0h required=%0h", tt, pwmPeriod, p[DW-1:0]); end
      n_cmp++;
      if (pwmRstN !== e_rstn) begin n_bad++;
        $display("FAIL pwm_rstn t=%0d got=%b required=%b", tt, pwmRstN, e_rstn); end
      n_cmp++;
      if (done !== e_done) begin n_bad++;
        $display("FAIL done t=%0d got=%b required=%b", tt, done, e_done); end
      n_cmp++;
      if (busy !== e_busy || cfgReady !== !e_busy) begin n_bad++;
        $display("FAIL busy_ready t=%0d got busy=%b ready=%b required busy=%b", tt, busy, cfgReady, e_busy); end
      n_cmp++;
      if (aborted !== e_ab || cfgErr !== 1'b0) begin n_bad++;
        $display("FAIL aborted t=%0d got=%b err=%b required=%b err=0", tt, aborted, cfgErr, e_ab); end
      abort = (abort_at > 0) && (tt == abort_at - 1);
    end
    abort     = 1'b0;
    m_period  = p;
    m_running = 1'b1;
    m_duty    = taken ? duty_at(abort_at - 1, t0, dd, start) : tgt;
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if (pwmRstN !== 1'b0 || pwmPeriod !== '0 || pwmDutyCycle !== '0 || cfgReady !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || cfgErr !== 1'b0) begin
      n_bad++;
      $display("FAIL %s got rstn=%b per=%0h duty=%0h rdy=%b busy=%b done=%b ab=%b err=%b required all 0",
               tag, pwmRstN, pwmPeriod, pwmDutyCycle, cfgReady, busy, done, aborted, cfgErr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_reset_values("reset_hold");
    end
    @(negedge clk); rst = 1'b1;
    check_reset_values("reset_release");
    @(posedge clk); #1;
    n_cmp++;
    if (cfgReady !== 1'b1 || pwmRstN !== 1'b0) begin n_bad++;
      $display("FAIL ready_after_reset got rdy=%b rstn=%b required 1 0", cfgReady, pwmRstN); end
    m_period = 0; m_duty = 0; m_running = 0;
  endtask

  task automatic test_basic_ramp();
    run_cfg(4, 3, 1, 2, 0, 0, 0);
  endtask

  task automatic test_no_reload_down();
    run_cfg(4, 1, 2, 1, 0, 0, 0);
  endtask

  task automatic test_clamp_and_err();
    run_cfg(2, 9, 0, 1, 0, 0, 0);
    run_cfg(0, 5, 1, 1, 0, 0, 0);
  endtask

  task automatic test_abort();
    run_cfg(8, 8, 1, 3, 13, 0, 0);
    run_cfg(5, 5, 1, 1, 1, 0, 0);
    run_cfg(5, 2, 1, 1, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    nxt_p = 3; nxt_t = 1; nxt_s = 1; nxt_d = 1;
    run_cfg(6, 6, 2, 2, 0, 1, -1);
    run_cfg(3, 1, 1, 1, 0, 0, 0);
  endtask

  task automatic test_boundary();
    run_cfg(64'hFFFF_FFFF, 64'hFFFF_FFF0, 0, 1, 0, 0, -1);
    run_cfg(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF, 0, 0, 0, -1);
    run_cfg(64'hFFFF_FFFF, 64'hFFFF_0000, 64'hFFFF, 1, 0, 0, -1);
    run_cfg(10, 10, 0, 1, 0, 0, -1);
    run_cfg(10, 1, 64'hFFFF, 2, 0, 0, -1);
  endtask

  task automatic test_random();
    longint p, t, s; int d, ab;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) p = 0;
      else if ($urandom_range(0, 1) == 1 && m_period != 0 && m_period < 64) p = m_period;
      else p = $urandom_range(1, 12);
      t  = $urandom_range(0, 15);
      s  = $urandom_range(0, 4);
      d  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_cfg(p, t, s, d, ab, 0, -1);
    end
  endtask

  task automatic test_mid_reset();
    drive_cfg(9, 9, 1, 2);
    @(negedge clk);
    @(posedge clk); #1;
    cfgValid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("mid_reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    m_period = 0; m_duty = 0; m_running = 0;
    run_cfg(3, 2, 1, 1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_ramp();
    test_no_reload_down();
    test_clamp_and_err();
    test_abort();
    test_back_to_back();
    test_boundary();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
